// File: rtl/obi_bank_router.sv
// Routes one OBI master onto NUM_BANKS bank ports by address; an in-order FIFO steers responses.
// Optional: define OBI_BANK_ROUTER_ERR_RESP_EN to complete requests to gated banks locally with an error.
package eros_obi_pkg;
  localparam int unsigned OBI_ADDR_W = 32;
  localparam int unsigned OBI_DATA_W = 32;

  typedef struct packed {
    logic                    req;
    logic                    we;
    logic [OBI_ADDR_W-1:0]   addr;
    logic [OBI_DATA_W-1:0]   wdata;
    logic [OBI_DATA_W/8-1:0] be;
  } obi_req_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    logic [OBI_DATA_W-1:0] rdata;
  } obi_resp_t;
endpackage

module obi_bank_router
  import eros_obi_pkg::*;
#(
  parameter int unsigned NUM_BANKS       = 2,
  parameter int unsigned BANK_ADDR_WIDTH = 15,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  obi_req_t                               master_req_i,
  output obi_resp_t                              master_resp_o,
  output obi_req_t  [NUM_BANKS-1:0]              bank_req_o,
  input  obi_resp_t [NUM_BANKS-1:0]              bank_resp_i,
  input  logic      [NUM_BANKS-1:0]              bank_on_i,
  output logic      [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                   err_o
);
  localparam int unsigned IDX_W = $clog2(NUM_BANKS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [31:0] ERR_RDATA = 32'hBADCAB1E;

  typedef struct packed {
    logic             is_local;
    logic [IDX_W-1:0] idx;
  } entry_t;

  entry_t             fifo_q [MAX_OUTSTANDING];
  entry_t             fifo_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  entry_t             tail_q, tail_d;

  logic [IDX_W-1:0]   tgt;
  logic               tgt_local;
  entry_t             tgt_entry;
  entry_t             head;
  logic               fifo_empty, fifo_full, fifo_last;
  logic               resp_rvalid;
  logic [31:0]        resp_rdata;
  logic               pop, accept, gnt, push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign tgt = master_req_i.addr[BANK_ADDR_WIDTH +: IDX_W];

`ifdef OBI_BANK_ROUTER_ERR_RESP_EN
  assign tgt_local = !bank_on_i[tgt];
`else
  assign tgt_local = 1'b0;
`endif

  assign tgt_entry  = '{is_local: tgt_local, idx: tgt};
  assign head       = fifo_q[rd_ptr_q];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_last  = (cnt_q == CNT_W'(1));

  // Response is steered purely by the FIFO head; local entries answer on their first head cycle.
  always_comb begin
    resp_rvalid = 1'b0;
    resp_rdata  = '0;
    if (!fifo_empty) begin
      if (head.is_local) begin
        resp_rvalid = 1'b1;
        resp_rdata  = ERR_RDATA;
      end else begin
        resp_rvalid = bank_resp_i[head.idx].rvalid;
        resp_rdata  = bank_resp_i[head.idx].rdata;
      end
    end
  end

  assign pop    = resp_rvalid;
  assign accept = !rst_i
                  && (!fifo_full || pop)
                  && (fifo_empty || (tail_q == tgt_entry) || (pop && fifo_last))
                  && (bank_on_i[tgt] || tgt_local);
  assign gnt    = accept && (tgt_local || bank_resp_i[tgt].gnt);
  assign push   = master_req_i.req && gnt;

  always_comb begin
    master_resp_o        = '0;
    master_resp_o.gnt    = gnt;
    master_resp_o.rvalid = resp_rvalid;
    master_resp_o.rdata  = resp_rdata;
  end

  // Payload is broadcast; only the selected, powered bank sees req.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_req_o[b]     = master_req_i;
      bank_req_o[b].req = master_req_i.req && accept && !tgt_local && (tgt == IDX_W'(b));
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    tail_d   = tail_q;
    if (push) begin
      fifo_d[wr_ptr_q] = tgt_entry;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      tail_d           = tgt_entry;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifo_q   <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      tail_q   <= '0;
    end else begin
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      tail_q   <= tail_d;
    end
  end

  assign outstanding_o = cnt_q;

`ifdef OBI_BANK_ROUTER_ERR_RESP_EN
  assign err_o = resp_rvalid && !fifo_empty && head.is_local;
`else
  assign err_o = 1'b0;
`endif

  // A bank answering while another target owns the head breaks the in-order contract.
  logic [NUM_BANKS-1:0] stray_rvalid;
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      stray_rvalid[b] = bank_resp_i[b].rvalid && !fifo_empty
                        && (head.is_local || (head.idx != IDX_W'(b)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (stray_rvalid == '0);
    end
  end

endmodule

// File: tb/tb_obi_bank_router.sv
// Bench for obi_bank_router: vector table, directed corner sequences and a randomized run against a queue model.
`timescale 1ns/1ps
module tb_obi_bank_router;
  import eros_obi_pkg::*;

  localparam int unsigned NB = 2;
  localparam logic [31:0] ERR_RDATA = 32'hBADCAB1E;
`ifdef OBI_BANK_ROUTER_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  obi_req_t             mreq_a, mreq_b;
  obi_resp_t            mresp_a, mresp_b;
  obi_req_t  [NB-1:0]   breq_a, breq_b;
  obi_resp_t [NB-1:0]   bresp_a, bresp_b;
  logic      [NB-1:0]   on_a;
  logic      [1:0]      outst_a;
  logic                 outst_b;
  logic                 err_a, err_b;

  obi_bank_router #(.NUM_BANKS(2), .BANK_ADDR_WIDTH(15), .MAX_OUTSTANDING(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .master_req_i(mreq_a), .master_resp_o(mresp_a),
    .bank_req_o(breq_a), .bank_resp_i(bresp_a), .bank_on_i(on_a),
    .outstanding_o(outst_a), .err_o(err_a));

  obi_bank_router #(.NUM_BANKS(2), .BANK_ADDR_WIDTH(15), .MAX_OUTSTANDING(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .master_req_i(mreq_b), .master_resp_o(mresp_b),
    .bank_req_o(breq_b), .bank_resp_i(bresp_b), .bank_on_i(2'b11),
    .outstanding_o(outst_b), .err_o(err_b));

  // Bank stubs for instance A: always ready, selectable response latency, never reset.
  int          lat_a;
  logic        ld;
  logic        ld_bank;
  logic [3:0]  ld_idx;
  logic [31:0] ld_val;
  logic [31:0] mem_a [NB][16] = '{default: 32'h0};
  logic        pv_a  [NB][3]  = '{default: 1'b0};
  logic [31:0] pd_a  [NB][3]  = '{default: 32'h0};

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      bresp_a[b].gnt    = breq_a[b].req;
      bresp_a[b].rvalid = pv_a[b][lat_a-1];
      bresp_a[b].rdata  = pd_a[b][lat_a-1];
    end
  end

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      for (int k = 2; k > 0; k--) begin
        pv_a[b][k] <= pv_a[b][k-1];
        pd_a[b][k] <= pd_a[b][k-1];
      end
      pv_a[b][0] <= breq_a[b].req && bresp_a[b].gnt;
      pd_a[b][0] <= breq_a[b].we ? 32'h0 : mem_a[b][breq_a[b].addr[5:2]];
      if (breq_a[b].req && breq_a[b].we) mem_a[b][breq_a[b].addr[5:2]] <= breq_a[b].wdata;
    end
    if (ld) mem_a[ld_bank][ld_idx] <= ld_val;
  end

  // Bank 0 stub for instance B: fixed 3-cycle latency, data derived from the address.
  logic        pv_b [3] = '{default: 1'b0};
  logic [31:0] pd_b [3] = '{default: 32'h0};
  always_comb begin
    bresp_b[0].gnt    = breq_b[0].req;
    bresp_b[0].rvalid = pv_b[2];
    bresp_b[0].rdata  = pd_b[2];
    bresp_b[1]        = '0;
  end
  always @(posedge clk) begin
    pv_b[2] <= pv_b[1];
    pd_b[2] <= pd_b[1];
    pv_b[1] <= pv_b[0];
    pd_b[1] <= pd_b[0];
    pv_b[0] <= breq_b[0].req;
    pd_b[0] <= {16'hB0B0, breq_b[0].addr[15:0]};
  end

  int n_pass, n_total;
  logic [31:0] shadow [NB][16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] breq_vec_a();
    return {breq_a[1].req, breq_a[0].req};
  endfunction

  task automatic preload(input int b, input int i, input logic [31:0] v);
    ld      = 1'b1;
    ld_bank = b[0];
    ld_idx  = i[3:0];
    ld_val  = v;
    shadow[b][i] = v;
    tick();
    ld = 1'b0;
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    mreq_a.req   = req;
    mreq_a.we    = we;
    mreq_a.addr  = addr;
    mreq_a.wdata = wdata;
    mreq_a.be    = 4'hF;
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  on;
    logic        exp_gnt;
    logic [1:0]  exp_breq;
  } vec_t;
  vec_t vt [8];

  typedef struct {
    bit          loc;
    int          bank;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q [$];

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; lat_a = 1; on_a = 2'b11;
    ld = 1'b0; ld_bank = 1'b0; ld_idx = '0; ld_val = '0;
    mreq_a = '0; mreq_b = '0;
    for (int b = 0; b < NB; b++) for (int i = 0; i < 16; i++) shadow[b][i] = 32'h0;

    vt[0] = '{1'b1, 1'b0, 32'h0000_0004, 2'b11, 1'b1,   2'b01};
    vt[1] = '{1'b1, 1'b0, 32'h0000_8000, 2'b11, 1'b1,   2'b10};
    vt[2] = '{1'b0, 1'b0, 32'h0000_8000, 2'b11, 1'b0,   2'b00};
    vt[3] = '{1'b1, 1'b0, 32'h0001_0008, 2'b11, 1'b1,   2'b01};
    vt[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 2'b11, 1'b1,   2'b10};
    vt[5] = '{1'b1, 1'b1, 32'h0000_7FFC, 2'b11, 1'b1,   2'b01};
    vt[6] = '{1'b1, 1'b0, 32'h0000_8010, 2'b01, ERR_EN, 2'b00};
    vt[7] = '{1'b1, 1'b0, 32'h0000_0004, 2'b10, ERR_EN, 2'b00};

    repeat (3) tick();
    @(negedge clk);
    chk("rst_outstanding", 32'(outst_a), 32'd0);
    chk("rst_rvalid", 32'(mresp_a.rvalid), 32'd0);
    chk("rst_gnt", 32'(mresp_a.gnt), 32'd0);
    chk("rst_bank_req", 32'(breq_vec_a()), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single-cycle decode/grant vectors from an idle router.
    for (int i = 0; i < 8; i++) begin
      drive_a(vt[i].req, vt[i].we, vt[i].addr, 32'h0);
      on_a = vt[i].on;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), 32'(mresp_a.gnt), 32'(vt[i].exp_gnt));
      chk($sformatf("vec%0d_bank_req", i), 32'(breq_vec_a()), 32'(vt[i].exp_breq));
      chk($sformatf("vec%0d_bcast_addr", i), breq_a[1].addr, vt[i].addr);
      tick();
      drive_a(1'b0, 1'b0, 32'h0, 32'h0);
      on_a = 2'b11;
      repeat (3) tick();
    end

    // Streaming reads from bank 0 with 1-cycle banks.
    preload(0, 0, 32'h11);
    preload(0, 1, 32'h22);
    preload(0, 2, 32'h33);
    preload(1, 4, 32'h5EED_1234);
    drive_a(1'b1, 1'b0, 32'h0000_0000, 32'h0);
    @(negedge clk);
    chk("stream_gnt0", 32'(mresp_a.gnt), 32'd1);
    chk("stream_rvalid0", 32'(mresp_a.rvalid), 32'd0);
    tick();
    drive_a(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    @(negedge clk);
    chk("stream_gnt1", 32'(mresp_a.gnt), 32'd1);
    chk("stream_rdata1", mresp_a.rvalid ? mresp_a.rdata : 32'hDEAD_0000, 32'h11);
    tick();
    drive_a(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    @(negedge clk);
    chk("stream_gnt2", 32'(mresp_a.gnt), 32'd1);
    chk("stream_rdata2", mresp_a.rvalid ? mresp_a.rdata : 32'hDEAD_0000, 32'h22);
    chk("stream_outstanding", 32'(outst_a), 32'd1);
    tick();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("stream_rdata3", mresp_a.rvalid ? mresp_a.rdata : 32'hDEAD_0000, 32'h33);
    tick();
    @(negedge clk);
    chk("stream_idle_rvalid", 32'(mresp_a.rvalid), 32'd0);
    chk("stream_idle_outstanding", 32'(outst_a), 32'd0);
    repeat (3) tick();

    // Bank switch with 2-cycle banks: one bubble, grant lands on the old bank's rvalid.
    lat_a = 2;
    drive_a(1'b1, 1'b1, 32'h0000_8000, 32'hA5A5_A5A5);
    shadow[1][0] = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("switch_wr_gnt", 32'(mresp_a.gnt), 32'd1);
    chk("switch_wr_bank_req", 32'(breq_vec_a()), 32'b10);
    tick();
    drive_a(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    @(negedge clk);
    chk("switch_bubble_gnt", 32'(mresp_a.gnt), 32'd0);
    chk("switch_bubble_bank_req", 32'(breq_vec_a()), 32'b00);
    tick();
    @(negedge clk);
    chk("switch_wr_rvalid", 32'(mresp_a.rvalid), 32'd1);
    chk("switch_rd_gnt", 32'(mresp_a.gnt), 32'd1);
    chk("switch_rd_bank_req", 32'(breq_vec_a()), 32'b01);
    tick();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("switch_gap_rvalid", 32'(mresp_a.rvalid), 32'd0);
    tick();
    @(negedge clk);
    chk("switch_rd_rdata", mresp_a.rvalid ? mresp_a.rdata : 32'hDEAD_0000, 32'h22);
    repeat (3) tick();
    lat_a = 1;
    repeat (2) tick();

    // Gated bank 1.
    on_a = 2'b01;
    drive_a(1'b1, 1'b0, 32'h0000_8010, 32'h0);
`ifdef OBI_BANK_ROUTER_ERR_RESP_EN
    @(negedge clk);
    chk("gated_gnt", 32'(mresp_a.gnt), 32'd1);
    chk("gated_bank_req", 32'(breq_vec_a()), 32'b00);
    tick();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("gated_rvalid", 32'(mresp_a.rvalid), 32'd1);
    chk("gated_rdata", mresp_a.rdata, ERR_RDATA);
    chk("gated_err", 32'(err_a), 32'd1);
    chk("gated_bank_req_after", 32'(breq_vec_a()), 32'b00);
    tick();
    @(negedge clk);
    chk("gated_err_pulse", 32'(err_a), 32'd0);
`else
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("gated_hold%0d", c), {mresp_a.gnt, breq_vec_a()}, 32'b000);
      tick();
    end
    on_a = 2'b11;
    @(negedge clk);
    chk("gated_on_gnt", 32'(mresp_a.gnt), 32'd1);
    chk("gated_on_bank_req", 32'(breq_vec_a()), 32'b10);
    tick();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("gated_on_rdata", mresp_a.rvalid ? mresp_a.rdata : 32'hDEAD_0000, 32'h5EED_1234);
    chk("gated_on_err", 32'(err_a), 32'd0);
`endif
    on_a = 2'b11;
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) tick();

    // Reset with two reads in flight; the stale bank rvalid must not surface.
    lat_a = 2;
    drive_a(1'b1, 1'b0, 32'h0000_0000, 32'h0);
    tick();
    drive_a(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    @(negedge clk);
    chk("rstmid_gnt2", 32'(mresp_a.gnt), 32'd1);
    tick();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rstmid_outstanding2", 32'(outst_a), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_outstanding0", 32'(outst_a), 32'd0);
    chk("rstmid_stale_rvalid", 32'(mresp_a.rvalid), 32'd0);
    chk("rstmid_bank_req", 32'(breq_vec_a()), 32'b00);
    chk("rstmid_err", 32'(err_a), 32'd0);
    repeat (4) tick();
    lat_a = 1;
    repeat (2) tick();

    // Depth-1 FIFO against a 3-cycle bank.
    mreq_b = '0;
    mreq_b.req = 1'b1; mreq_b.addr = 32'h0000_0000; mreq_b.be = 4'hF;
    @(negedge clk);
    chk("full_gnt_first", 32'(mresp_b.gnt), 32'd1);
    tick();
    mreq_b.addr = 32'h0000_0004;
    @(negedge clk);
    chk("full_hold1", {mresp_b.gnt, 1'b0, outst_b}, 32'b001);
    tick();
    @(negedge clk);
    chk("full_hold2", 32'(mresp_b.gnt), 32'd0);
    tick();
    @(negedge clk);
    chk("full_rvalid_first", 32'(mresp_b.rvalid), 32'd1);
    chk("full_rdata_first", mresp_b.rdata, 32'hB0B0_0000);
    chk("full_gnt_second", 32'(mresp_b.gnt), 32'd1);
    tick();
    mreq_b = '0;
    repeat (2) begin
      @(negedge clk);
      chk("full_gap_rvalid", 32'(mresp_b.rvalid), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("full_rdata_second", mresp_b.rvalid ? mresp_b.rdata : 32'hDEAD_0000, 32'hB0B0_0004);
    tick();

    // Randomized traffic against a queue model of the routing rules (1-cycle banks).
    begin
      bit          pend, loc, pop_exp, acc, exp_gnt, loc0;
      int          bnk, idx, wait_cnt;
      logic        we;
      logic [31:0] wd, addr;
      pend = 0; bnk = 0; idx = 0; we = 0; wd = 0; addr = 0; wait_cnt = 0;
      q.delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
        on_a = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
        if (!pend && $urandom_range(3) != 0) begin
          pend = 1; wait_cnt = 0;
          bnk  = $urandom_range(1);
          idx  = $urandom_range(15);
          we   = $urandom_range(1);
          wd   = $urandom;
          addr = ($urandom & 32'hFFFF_7FC0) | (32'(bnk) << 15) | (32'(idx) << 2);
        end
        drive_a(pend, we, addr, wd);
        @(negedge clk);
        pop_exp = (q.size() != 0) && (q[0].due <= cyc);
        loc0    = 0;
        if (pop_exp) loc0 = q[0].loc;
        loc = ERR_EN && !on_a[bnk];
        acc = (q.size() < 2 || pop_exp) && (on_a[bnk] || loc);
        if (q.size() != 0)
          acc = acc && ((q[$].loc == loc && q[$].bank == bnk) || (pop_exp && q.size() == 1));
        exp_gnt = pend && acc;
        chk("rnd_rvalid", 32'(mresp_a.rvalid), 32'(pop_exp));
        if (pop_exp) chk("rnd_rdata", mresp_a.rdata, q[0].data);
        chk("rnd_err", 32'(err_a), 32'(loc0));
        chk("rnd_gnt", 32'(mresp_a.gnt), 32'(exp_gnt));
        chk("rnd_bank_req", 32'(breq_vec_a()), (exp_gnt && !loc) ? (32'd1 << bnk) : 32'd0);
        chk("rnd_outstanding", 32'(outst_a), 32'(q.size()));
        if (pop_exp) void'(q.pop_front());
        if (exp_gnt) begin
          exp_t e;
          e.loc  = loc;
          e.bank = bnk;
          e.due  = cyc + 1;
          e.data = loc ? ERR_RDATA : (we ? 32'h0 : shadow[bnk][idx]);
          if (!loc && we) shadow[bnk][idx] = wd;
          q.push_back(e);
          pend = 0;
        end else if (pend) begin
          wait_cnt++;
          if (wait_cnt > 60) begin
            chk("rnd_grant_timeout", 32'(wait_cnt), 32'd0);
            pend = 0;
          end
        end
        tick();
      end
    end
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
